// File: rtl/shift_normalizer_8bit_pkg.sv
// Shared definitions for the sequential shift normalizer: state encoding,
// direction constants and the default data/count widths.
package shift_normalizer_8bit_pkg;

  localparam int SN_WIDTH = 8;
  localparam int SN_CNT_W = $clog2(SN_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Same sense as the combinational shifter's Lr input.
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_normalizer_8bit.sv
// Shifts a word one bit per clock toward the chosen end until that end bit is 1,
// then holds the normalized word and the recovered shift count until taken.
module shift_normalizer_8bit
  import shift_normalizer_8bit_pkg::*;
#(
  parameter int WIDTH = SN_WIDTH,
  parameter int CNT_W = SN_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_n,
  output logic             out_zero
);

  state_t             state_reg;
  logic [WIDTH-1:0]   data_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               dir_reg;
  logic               zero_reg;
  logic               out_valid_reg;

  // Gating with rst_n keeps the producer from seeing ready while reset is held.
  assign in_ready  = (state_reg == IDLE) && rst_n;
  assign out_valid = out_valid_reg;
  assign out_data  = data_reg;
  assign out_n     = cnt_reg;
  assign out_zero  = zero_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      data_reg      <= '0;
      cnt_reg       <= '0;
      dir_reg       <= DIR_RIGHT;
      zero_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            data_reg  <= in_data;
            dir_reg   <= in_lr;
            cnt_reg   <= '0;
            zero_reg  <= 1'b0;
            state_reg <= SHIFT;
          end
        end
        SHIFT: begin
          if (data_reg == '0) begin
            zero_reg      <= 1'b1;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else if ((dir_reg == DIR_LEFT) ? data_reg[WIDTH-1] : data_reg[0]) begin
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            // A nonzero word reaches its target bit within WIDTH-1 steps, so cnt cannot wrap.
            data_reg <= (dir_reg == DIR_LEFT) ? (data_reg << 1) : (data_reg >> 1);
            cnt_reg  <= cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_normalizer_8bit.sv
// Directed bench for shift_normalizer_8bit: vector table, backpressure,
// mid-operation reset and round-trip checks on random words.
module tb_shift_normalizer_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_lr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_n;
  logic       out_zero;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_normalizer_8bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_lr     (in_lr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_n     (out_n),
    .out_zero  (out_zero)
  );

  typedef struct {
    logic       lr;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic [2:0] exp_n;
    logic       exp_zero;
    int         exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called one time unit after a rising edge with the block idle.
  task automatic do_xfer(input logic lr, input logic [7:0] d,
                         output logic [7:0] od, output logic [2:0] on,
                         output logic oz, output int lat);
    in_valid = 1'b1;
    in_data  = d;
    in_lr    = lr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_lr    = ~lr;
    in_data  = ~d;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    od = out_data;
    on = out_n;
    oz = out_zero;
  endtask

  initial begin
    logic [7:0] od;
    logic [2:0] on;
    logic       oz;
    int         lat;
    logic [7:0] d;
    logic       lr;
    logic [7:0] restored;
    int         k;

    vecs[0] = '{1'b1, 8'h13, 8'h98, 3'd3, 1'b0, 4};
    vecs[1] = '{1'b0, 8'hA0, 8'h05, 3'd5, 1'b0, 6};
    vecs[2] = '{1'b1, 8'h80, 8'h80, 3'd0, 1'b0, 1};
    vecs[3] = '{1'b1, 8'h01, 8'h80, 3'd7, 1'b0, 8};
    vecs[4] = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b0, 1};
    vecs[5] = '{1'b0, 8'h80, 8'h01, 3'd7, 1'b0, 8};
    vecs[6] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b1, 1};
    vecs[7] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1};
    vecs[8] = '{1'b1, 8'h40, 8'h80, 3'd1, 1'b0, 2};
    vecs[9] = '{1'b0, 8'h0C, 8'h03, 3'd2, 1'b0, 3};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_lr = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("reset in_ready",  int'(in_ready),  0);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_data",  int'(out_data),  0);
    check("reset out_n",     int'(out_n),     0);
    check("reset out_zero",  int'(out_zero),  0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle in_ready", int'(in_ready), 1);

    for (int i = 0; i < 10; i++) begin
      do_xfer(vecs[i].lr, vecs[i].data, od, on, oz, lat);
      $display("vec %0d lr=%0d data=%02h -> data=%02h n=%0d zero=%0d lat=%0d",
               i, vecs[i].lr, vecs[i].data, od, on, oz, lat);
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d out_data", i), int'(od), int'(vecs[i].exp_data));
      check($sformatf("vec%0d out_n", i), int'(on), int'(vecs[i].exp_n));
      check($sformatf("vec%0d out_zero", i), int'(oz), int'(vecs[i].exp_zero));
      @(posedge clk); #1;
      check($sformatf("vec%0d valid drop", i), int'(out_valid), 0);
      check($sformatf("vec%0d ready back", i), int'(in_ready), 1);
    end

    // Backpressure: result held while a competing word is offered.
    out_ready = 1'b0;
    do_xfer(1'b1, 8'h13, od, on, oz, lat);
    check("bp latency", lat, 4);
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0] ? 1'b0 : 1'b1;
      in_data  = 8'h55;
      in_lr    = 1'b0;
      @(posedge clk); #1;
      check($sformatf("bp%0d out_valid", c), int'(out_valid), 1);
      check($sformatf("bp%0d out_data", c),  int'(out_data),  8'h98);
      check($sformatf("bp%0d out_n", c),     int'(out_n),     3);
      check($sformatf("bp%0d in_ready", c),  int'(in_ready),  0);
    end
    $display("backpressure held data=%02h n=%0d for 5 clocks", out_data, out_n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release in_ready",  int'(in_ready),  1);
    check("bp release out_valid", int'(out_valid), 0);
    repeat (3) @(posedge clk);
    #1;
    check("bp 0x55 not taken", int'(out_valid), 0);
    check("bp still idle", int'(in_ready), 1);

    // Reset three clocks into a seven-shift normalization.
    in_valid = 1'b1; in_data = 8'h01; in_lr = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", int'(out_valid), 0);
    check("midrst out_n",     int'(out_n),     0);
    check("midrst in_ready",  int'(in_ready),  0);
    $display("mid-operation reset: out_valid=%0d out_n=%0d in_ready=%0d", out_valid, out_n, in_ready);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_xfer(1'b1, 8'h40, od, on, oz, lat);
    $display("post-reset lr=1 data=40 -> data=%02h n=%0d lat=%0d", od, on, lat);
    check("postrst out_data", int'(od), 8'h80);
    check("postrst out_n",    int'(on), 1);
    check("postrst latency",  lat, 2);
    @(posedge clk); #1;

    // Round trip on random nonzero words.
    for (int t = 0; t < 8; t++) begin
      d  = 8'($urandom_range(1, 255));
      lr = 1'($urandom_range(0, 1));
      k = 0;
      for (int b = 0; b < 8; b++) begin
        if (lr ? d[7-b] : d[b]) break;
        k++;
      end
      do_xfer(lr, d, od, on, oz, lat);
      restored = lr ? (od >> on) : (od << on);
      $display("rt %0d lr=%0d data=%02h -> data=%02h n=%0d lat=%0d", t, lr, d, od, on, lat);
      check($sformatf("rt%0d restore", t), int'(restored), int'(d));
      check($sformatf("rt%0d target bit", t), int'(lr ? od[7] : od[0]), 1);
      check($sformatf("rt%0d out_n", t), int'(on), k);
      check($sformatf("rt%0d latency", t), lat, k + 1);
      check($sformatf("rt%0d out_zero", t), int'(oz), 0);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_normalizer_8bit.md
Name: shift_normalizer_8bit

Overview:
Sequential inverse of the team's combinational 8-bit left/right shifter. It takes an 8-bit word and shifts it one bit per clock until the target end bit is 1. It then reports the normalized word and the shift count n it recovered. Applying the opposite-direction shift by n to the result restores the original word. It sits between a producer and a consumer, with a valid/ready handshake on each side.

Parameters:
WIDTH, 8, data width in bits (only 8 is verified)
CNT_W, 3, shift-count width, equal to log2(WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer offers in_data/in_lr
in_ready  output  1  block can accept a word
in_data  input  WIDTH  word to normalize
in_lr  input  1  1 = normalize toward MSB (left), 0 = toward LSB (right)
out_valid  output  1  result available
out_ready  input  1  consumer takes the result
out_data  output  WIDTH  normalized word
out_n  output  CNT_W  number of single-bit shifts applied
out_zero  output  1  input word was all zeros

Behaviour:
- Clock and reset are fixed: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, out_valid=0, out_data=0, out_n=0, out_zero=0, internal data/count/dir registers 0.
- in_ready = (state==IDLE) AND rst_n, so it is 0 while reset is held.
- States:
  - IDLE: on in_valid&&in_ready, load data_r=in_data, dir_r=in_lr, cnt=0, zero_r=0, then go to SHIFT.
  - SHIFT, each clock:
    - if data_r==0: set zero_r=1, go to DONE.
    - else if the target bit is set (data_r[WIDTH-1] for dir_r=1, data_r[0] for dir_r=0): go to DONE.
    - else shift data_r by 1 in direction dir_r (zero fill) and increment cnt.
  - DONE: out_valid=1. out_data/out_n/out_zero show data_r/cnt/zero_r and stay stable. When out_ready=1, go to IDLE; out_valid drops the next cycle.
- Latency: with k = leading zeros (left) or trailing zeros (right), out_valid rises k+1 clocks after the accepting edge.
  - k ranges 0..7.
  - Zero input: latency 1, out_n=0, out_data=0.
- cnt never exceeds WIDTH-1, so there is no wrap-around. Any nonzero word has its target bit set by shift 7.
- Throughput: one word per k+3 clocks minimum. No acceptance in SHIFT or DONE; in_valid there is ignored, and in_data need not be held.
- in_lr is sampled only at acceptance. Changes afterwards have no effect.
- out_valid must not depend combinationally on out_ready.
- Reset mid-operation: all state clears immediately (asynchronously), including a pending DONE result. No partial result is ever presented.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - direction constants DIR_LEFT=1'b1, DIR_RIGHT=1'b0, matching the shifter's Lr convention
  - CNT_W derivation
- No sub-module is needed. The single-step shift and target-bit test stay inline in the datapath always block.

Test Plan:
- in_lr=1, in_data=0x13, out_ready=1 -> out_valid 4 clocks after accept; out_data=0x98, out_n=3, out_zero=0.
- in_lr=0, in_data=0xA0 -> out_valid 6 clocks after accept; out_data=0x05, out_n=5, out_zero=0.
- Boundaries, in_lr=1:
  - in_data=0x80 -> n=0, data 0x80, latency 1.
  - in_data=0x01 -> n=7, data 0x80, latency 8.
  - Repeat both mirrored with in_lr=0: 0x01 gives n=0, 0x80 gives n=7 with data 0x01.
- in_data=0x00 (either direction) -> latency 1, out_zero=1, out_n=0, out_data=0x00.
- Backpressure: hold out_ready=0 for 5 clocks after out_valid while pulsing in_valid with 0x55 -> outputs stable, in_ready=0, 0x55 not accepted. Raise out_ready -> IDLE next clock, in_ready=1.
- Reset: accept 0x01 with in_lr=1, assert rst_n=0 mid-clock 3 clocks later -> out_valid=0, out_n=0, in_ready=0 immediately. After release, a new word of 0x40 gives n=1, data 0x80.
- Round-trip check on random nonzero words: re-shifting out_data by out_n in the opposite direction reproduces in_data.
